// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the seven-segment display scheduler.
// Requester count limits, default divider values and owner index width.
package seg_disp_pkg;

    localparam int NREQ_MIN       = 2;
    localparam int NREQ_MAX       = 8;
    localparam int OWN_W          = 3;
    localparam int OWN_W1         = OWN_W + 1;
    localparam int SCAN_DIV_W_DEF = 18;
    localparam int FLASH_DIV_DEF  = 25000000;
    localparam int HOLD_CYC_DEF   = 50000000;

    // Round-robin successor of a winner index, wrapping at n.
    function automatic logic [OWN_W-1:0] rr_next(
        input logic [OWN_W-1:0] idx,
        input int               n
    );
        logic [OWN_W:0] s;
        s = {1'b0, idx} + 1'b1;
        if (s >= OWN_W1'(n)) s = '0;
        return s[OWN_W-1:0];
    endfunction

endpackage

// File: rtl/seg_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap,
// returns a one-hot grant plus encoded index, advances on a taken grant.
import seg_disp_pkg::*;

module seg_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [OWN_W-1:0] idx,
    output logic             valid
);

    logic [OWN_W-1:0]    ptr;
    logic [NREQ_MAX-1:0] req_w;
    logic [OWN_W:0]      cand;
    logic                hit;

    assign req_w = NREQ_MAX'(req);
    assign valid = en && hit;

    // Scan offsets high to low so the nearest set request wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + OWN_W1'(k);
            if (cand >= OWN_W1'(NREQ)) cand = cand - OWN_W1'(NREQ);
            if (req_w[cand[OWN_W-1:0]]) begin
                hit = 1'b1;
                idx = cand[OWN_W-1:0];
            end
        end
    end

    // One-hot grant, only when the arbiter is allowed to grant.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++)
            gnt[i] = valid && (idx == OWN_W'(i));
    end

    // Pointer moves just past the winner on every taken grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (valid) ptr <= rr_next(idx, NREQ);
    end

endmodule

// File: rtl/seg_disp_ctrl.sv
// Shared 4-digit seven-segment scheduler: round-robin owner, scan and flash timing.
// Define SEG_HOLD_EN to hold each grant for HOLD_CYC cycles before re-arbitrating.
import seg_disp_pkg::*;

module seg_disp_ctrl #(
    parameter int NREQ       = 4,
    parameter int SCAN_DIV_W = SCAN_DIV_W_DEF,
    parameter int FLASH_DIV  = FLASH_DIV_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_num,
    input  logic [4*NREQ-1:0]    req_point,
    input  logic [4*NREQ-1:0]    req_blink,
    output logic [NREQ-1:0]      ack,
    output logic [OWN_W-1:0]     owner,
    output logic                 busy,
    output logic [31:0]          disp_num,
    output logic [3:0]           pointing,
    output logic [3:0]           blinking,
    output logic [1:0]           Scanning,
    output logic                 flash_clk
);

    localparam int FW = $clog2(FLASH_DIV + 1);

    logic [NREQ-1:0]       gnt;
    logic [OWN_W-1:0]      win;
    logic                  go;
    logic                  arb_en;
    logic [31:0]           sel_num;
    logic [3:0]            sel_point;
    logic [3:0]            sel_blink;
    logic [SCAN_DIV_W-1:0] scan_cnt;
    logic [FW-1:0]         flash_cnt;

`ifdef SEG_HOLD_EN
    localparam int HW = $clog2(HOLD_CYC + 1);
    logic [HW-1:0] hold_cnt;

    assign arb_en = !busy;

    // Hold window: busy for HOLD_CYC cycles after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else if (go) begin
            busy     <= 1'b1;
            hold_cnt <= HW'(HOLD_CYC - 1);
        end else if (busy) begin
            if (hold_cnt == '0) busy <= 1'b0;
            else hold_cnt <= hold_cnt - 1'b1;
        end
    end
`else
    assign arb_en = 1'b1;
    assign busy   = 1'b0;
`endif

    seg_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (arb_en),
        .gnt   (gnt),
        .idx   (win),
        .valid (go)
    );

    // Select the winner's display data.
    always_comb begin
        sel_num   = '0;
        sel_point = '0;
        sel_blink = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_num   = req_num[32*i +: 32];
                sel_point = req_point[4*i +: 4];
                sel_blink = req_blink[4*i +: 4];
            end
        end
    end

    // Latch winner data together with the one-cycle ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack      <= '0;
            owner    <= '0;
            disp_num <= '0;
            pointing <= '0;
            blinking <= '0;
        end else begin
            ack <= go ? gnt : '0;
            if (go) begin
                owner    <= win;
                disp_num <= sel_num;
                pointing <= sel_point;
                blinking <= sel_blink;
            end
        end
    end

    // Free-running scan counter; top two bits pick the digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scan_cnt <= '0;
        else scan_cnt <= scan_cnt + 1'b1;
    end

    assign Scanning = scan_cnt[SCAN_DIV_W-1 -: 2];

    // Flash divider toggles flash_clk every FLASH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
            flash_clk <= 1'b0;
        end else if (flash_cnt == FW'(FLASH_DIV - 1)) begin
            flash_cnt <= '0;
            flash_clk <= ~flash_clk;
        end else begin
            flash_cnt <= flash_cnt + 1'b1;
        end
    end

endmodule
